sophiali_seg_shifter: RTL
=========================

Name: sophiali_seg_shifter

Overview:
- Display-side counterpart to the calculator accumulator.
- Takes the 8-bit accumulator value and encodes it as two hex digits on 7-segment patterns.
- Serialises the 16-bit segment frame to external cascaded shift registers (74HC595-style) using a serial clock, data and latch pulse.
- Frees the design from needing 16 parallel segment pins: 3 output pins drive both displays.

Parameters:
- CLK_DIV, 4: system clocks per serial-clock half-period; legal range >= 1.
- SEG_ACTIVE_LOW, 0: 1 inverts every frame bit for common-anode displays.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- value  in  8  accumulator value; [7:4] high digit, [3:0] low digit
- load  in  1  request to send a frame; sampled only in IDLE
- blank_lead  in  1  1 blanks the high digit when value[7:4]==0
- busy  out  1  high while a frame is being shifted or latched
- done  out  1  one-cycle pulse when a frame completes
- sclk  out  1  serial clock to the shift registers
- sdata  out  1  serial data, stable across every sclk rising edge
- latch  out  1  storage-register latch pulse

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; busy, done, sclk, sdata and latch all 0; counters cleared.
  - A reset mid-frame aborts immediately with no latch pulse.
  - The external display keeps its previously latched frame.
- Segment byte format: {dp,g,f,e,d,c,b,a}, with dp always 0.
- Hex encoding:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Frame = {seg(value[7:4]), seg(value[3:0])}.
  - When blank_lead=1 and value[7:4]==0, the high byte is 00.
  - The whole frame is inverted when SEG_ACTIVE_LOW=1, after blanking (a blanked digit becomes FF).
- value and blank_lead are captured into the frame register on the accepting edge; later changes do not affect the frame in flight.
- States:
  - IDLE: busy=0. On load=1, capture the frame, go to SHIFT, set busy=1, sdata=frame[15], sclk=0, bit_cnt=0, div_cnt=0.
  - SHIFT: per bit, sclk stays low for CLK_DIV cycles, then high for CLK_DIV cycles. On the high-to-low transition, sdata advances to the next bit, MSB first (bit 15 down to bit 0). After the high phase of bit 0, sclk=0, sdata=0, go to LATCH.
  - LATCH: latch=1 for CLK_DIV cycles, then latch=0, busy=0, done=1, go to IDLE.
- done is high during the first IDLE cycle only.
  - load in that same cycle is accepted, so back-to-back frames run with exactly one idle cycle between them.
- load while busy=1 is ignored, not queued.
- Latency:
  - busy is high for exactly 33*CLK_DIV cycles: 32*CLK_DIV for shifting plus CLK_DIV for latching.
  - The first sclk rise occurs CLK_DIV cycles after the accepting edge.
- Exactly 16 sclk rising edges and one latch pulse occur per frame.
  - sclk and latch are never high simultaneously.
  - All outputs are registered (glitch-free).
- Counter widths:
  - div_cnt is $clog2(CLK_DIV+1) bits.
  - bit_cnt is 4 bits; it wraps 15 to 0 only on the transition to LATCH.

Decomposition:
- Shared package sophiali_pkg holds:
  - the state enum {IDLE, SHIFT, LATCH}
  - the 16-entry hex-to-segment constant table
  - the SEG_BLANK constant (8'h00)
- One combinational sub-module, sophiali_hex7seg (4-bit nibble in, 8-bit segment byte out), instantiated twice, once per digit.
- The top level holds the FSM, dividers and shift register.

Test Plan:
- value=8'h3A, blank_lead=0, CLK_DIV=4, pulse load. Sample sdata on each sclk rise: expect 16'h4F77 MSB first, 16 rises, then latch high 4 cycles, busy high 132 cycles, one done pulse.
- value=8'h05, blank_lead=1: frame 16'h006D. Same value with blank_lead=0: frame 16'h3F6D.
- SEG_ACTIVE_LOW=1, value=8'hFF: frame 16'h8E8E.
- Pulse load again at cycle 40 of a frame with a different value: ignored. The frame stays unchanged, busy is not extended, and no second frame starts.
- Hold load=1 continuously with value=8'h12: frames repeat with exactly one idle cycle (done cycle) between the end of one busy period and the start of the next; each frame is 16'h065B.
- Assert reset_n=0 mid-SHIFT (after 7 sclk rises): all outputs 0 asynchronously, no latch pulse. After release, a new load of 8'h80 sends 16'h7F3F cleanly.

Source files
------------

// File: rtl/sophiali_pkg.sv
//------------------------------------------------------------------------------
// Module   : sophiali_pkg
// Brief    : Shared FSM state type and hex-to-7-segment table for the display path
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sophiali_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Segment byte is {dp,g,f,e,d,c,b,a}; entry 0 is the rightmost element
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

`default_nettype wire

// File: rtl/sophiali_hex7seg.sv
//------------------------------------------------------------------------------
// Module   : sophiali_hex7seg
// Brief    : Combinational nibble to 7-segment byte encoder
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sophiali_hex7seg
  import sophiali_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

`default_nettype wire

// File: rtl/sophiali_seg_shifter.sv
//------------------------------------------------------------------------------
// Module   : sophiali_seg_shifter
// Brief    : Encodes an 8-bit value as two hex digits and shifts the 16-bit
//            segment frame into cascaded 74HC595-style registers
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sophiali_seg_shifter
  import sophiali_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] value,
  input  logic       load,
  input  logic       blank_lead,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       sdata,
  output logic       latch
);

  localparam int                 c_div_w    = $clog2(CLK_DIV + 1);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);

  logic [7:0]  w_seg_hi;
  logic [7:0]  w_seg_lo;
  logic [7:0]  w_hi_byte;
  logic [15:0] w_frame_raw;
  logic [15:0] w_frame;
  logic        w_div_wrap;

  state_t             r_state;
  logic [c_div_w-1:0] r_div_cnt;
  logic [3:0]         r_bit_cnt;
  logic [14:0]        r_shift;
  logic               r_busy;
  logic               r_done;
  logic               r_sclk;
  logic               r_sdata;
  logic               r_latch;

  sophiali_hex7seg u_hex_hi (
    .nibble (value[7:4]),
    .seg    (w_seg_hi)
  );

  sophiali_hex7seg u_hex_lo (
    .nibble (value[3:0]),
    .seg    (w_seg_lo)
  );

  // Polarity inversion comes after blanking so a blanked digit reads all-off
  assign w_hi_byte   = (blank_lead && (value[7:4] == 4'h0)) ? SEG_BLANK : w_seg_hi;
  assign w_frame_raw = {w_hi_byte, w_seg_lo};
  assign w_frame     = (SEG_ACTIVE_LOW != 0) ? ~w_frame_raw : w_frame_raw;
  assign w_div_wrap  = (r_div_cnt == c_div_last);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= 4'd0;
      r_shift   <= 15'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sclk    <= 1'b0;
      r_sdata   <= 1'b0;
      r_latch   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_shift   <= w_frame[14:0];
            r_sdata   <= w_frame[15];
            r_sclk    <= 1'b0;
            r_bit_cnt <= 4'd0;
            r_div_cnt <= '0;
            r_busy    <= 1'b1;
            r_state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (w_div_wrap) begin
            r_div_cnt <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              // Data only moves on the falling edge so it is settled at every rise
              r_sclk    <= 1'b0;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd15) begin
                r_sdata <= 1'b0;
                r_latch <= 1'b1;
                r_state <= LATCH;
              end else begin
                r_sdata <= r_shift[14];
                r_shift <= {r_shift[13:0], 1'b0};
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + c_div_one;
          end
        end

        LATCH: begin
          if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_latch   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_div_cnt <= r_div_cnt + c_div_one;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign sclk  = r_sclk;
  assign sdata = r_sdata;
  assign latch = r_latch;

endmodule

`default_nettype wire
